// File: rtl/lcd_pkg.sv
// Shared types, pin map and init table for the HD44780 command engine.
package lcd_pkg;

  typedef enum logic [2:0] {PWRUP, IDLE, SETUP, PULSE, HOLD, EXEC} state_t;

  // Bit positions inside the packed 32-bit LCD pin word.
  localparam int LCD_ON = 31;
  localparam int LCD_EN = 10;
  localparam int LCD_RS = 9;
  localparam int LCD_RW = 8;

  // Power-up sequence: 8-bit bus/2 lines, display on, clear, entry mode.
  localparam int INIT_LEN   = 4;
  localparam int INIT_SEL_W = $clog2(INIT_LEN);
  localparam int INIT_IDX_W = $clog2(INIT_LEN + 1);
  // NOTE: a constant table, not storage; it needs no reset and no write port.
  localparam logic [7:0] INIT_ROM [INIT_LEN] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  // Clear (0x01) and home (0x02/0x03) are the slow commands: upper six bits zero.
  localparam logic [7:0] CLR_HOME_MASK = 8'hFC;

  function automatic logic is_clr_home(input logic rs, input logic [7:0] data);
    return !rs && ((data & CLR_HOME_MASK) == 8'h00) && (data[1:0] != 2'b00);
  endfunction

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Pin word for a given phase; RW is tied low because the panel is write-only.
  function automatic logic [31:0] pack_pins(input state_t st, input logic rs,
                                            input logic [7:0] data);
    logic [31:0] pins;
    pins         = '0;
    pins[LCD_ON] = 1'b1;
    pins[LCD_RW] = 1'b0;
    if (st inside {SETUP, PULSE, HOLD, EXEC}) begin
      pins[LCD_RS] = rs;
      pins[7:0]    = data;
    end
    pins[LCD_EN] = (st == PULSE);
    return pins;
  endfunction

endpackage

// File: rtl/lcd_cmd_engine_if.sv
// Write channel from the LSU into the LCD command engine (valid/ready).
interface lcd_cmd_engine_if;
  logic       wr_vld;
  logic       wr_rdy;
  logic       wr_rs;
  logic [7:0] wr_data;

  modport master (output wr_vld, wr_rs, wr_data, input wr_rdy);
  modport slave  (input wr_vld, wr_rs, wr_data, output wr_rdy);
endinterface

// File: rtl/lcd_timer.sv
// Loadable down-counter that parks at zero; o_zero marks the last cycle of a phase.
module lcd_timer #(
  parameter int             W       = 8,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] count;

  // Reload on request, otherwise count down and stop at zero (never wraps).
  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
    if (i_reset)            count <= RST_VAL;
    else if (i_load)        count <= i_load_val;
    else if (count != '0)   count <= count - 1'b1;
  end

  assign o_zero = (count == '0);

endmodule

// File: rtl/lcd_cmd_engine.sv
// HD44780 driver: power-up init, then one setup/EN-pulse/hold/execute cycle per write.
module lcd_cmd_engine
  import lcd_pkg::*;
#(
  parameter int unsigned T_PWRUP = 750000,
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_EN    = 25,
  parameter int unsigned T_HOLD  = 2,
  parameter int unsigned T_CMD   = 2000,
  parameter int unsigned T_CLR   = 82000
) (
  input  logic                i_clk,
  input  logic                i_reset,
  lcd_cmd_engine_if.slave     wr,
  output logic                o_busy,
  output logic [31:0]         o_io_lcd
);

  localparam int unsigned T_MAX = umax(umax(umax(T_PWRUP, T_SETUP), umax(T_EN, T_HOLD)),
                                       umax(T_CMD, T_CLR));
  localparam int CW = $clog2(T_MAX) + 1;

  // Each phase loads N-1 so that it lasts exactly N cycles.
  localparam logic [CW-1:0] LD_PWRUP = CW'(T_PWRUP - 1);
  localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] LD_EN    = CW'(T_EN - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] LD_CMD   = CW'(T_CMD - 1);
  localparam logic [CW-1:0] LD_CLR   = CW'(T_CLR - 1);

  localparam logic [INIT_IDX_W-1:0] INIT_END = INIT_IDX_W'(INIT_LEN);

  state_t                  state;
  logic                    lat_rs;
  logic [7:0]              lat_data;
  logic [INIT_IDX_W-1:0]   init_idx;
  logic                    init_pending;
  logic                    accept;
  logic                    tmr_zero;
  logic                    tmr_load;
  logic [CW-1:0]           tmr_val;

  assign init_pending = (init_idx != INIT_END);
  assign accept       = wr.wr_vld && (state == IDLE);
  assign wr.wr_rdy    = (state == IDLE);
  assign o_busy       = (state != IDLE);

  lcd_timer #(.W(CW), .RST_VAL(LD_PWRUP)) u_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (tmr_load),
    .i_load_val (tmr_val),
    .o_zero     (tmr_zero)
  );

  // Reload the timer with the length of whichever phase the FSM enters next.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a variable unassigned.
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state)
      PWRUP: if (tmr_zero) begin tmr_load = 1'b1; tmr_val = LD_SETUP; end
      IDLE:  if (accept)   begin tmr_load = 1'b1; tmr_val = LD_SETUP; end
      SETUP: if (tmr_zero) begin tmr_load = 1'b1; tmr_val = LD_EN;    end
      PULSE: if (tmr_zero) begin tmr_load = 1'b1; tmr_val = LD_HOLD;  end
      HOLD:  if (tmr_zero) begin
        tmr_load = 1'b1;
        tmr_val  = is_clr_home(lat_rs, lat_data) ? LD_CLR : LD_CMD;
      end
      EXEC:  if (tmr_zero && init_pending) begin tmr_load = 1'b1; tmr_val = LD_SETUP; end
      default: ;
    endcase
  end

  // Phase sequencing, byte latch and registered pin word (one cycle behind the state).
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= PWRUP;
      init_idx <= '0;
      lat_rs   <= 1'b0;
      lat_data <= '0;
      o_io_lcd <= '0;
    end else begin
      o_io_lcd <= pack_pins(state, lat_rs, lat_data);
      unique case (state)
        PWRUP: if (tmr_zero) begin
          lat_rs   <= 1'b0;
          lat_data <= INIT_ROM[0];
          init_idx <= INIT_IDX_W'(1);
          state    <= SETUP;
        end
        IDLE: if (accept) begin
          lat_rs   <= wr.wr_rs;
          lat_data <= wr.wr_data;
          state    <= SETUP;
        end
        SETUP: if (tmr_zero) state <= PULSE;
        PULSE: if (tmr_zero) state <= HOLD;
        HOLD:  if (tmr_zero) state <= EXEC;
        EXEC: if (tmr_zero) begin
          if (init_pending) begin
            lat_rs   <= 1'b0;
            lat_data <= INIT_ROM[init_idx[INIT_SEL_W-1:0]];
            init_idx <= init_idx + 1'b1;
            state    <= SETUP;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= PWRUP;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_cmd_engine.sv
// Directed bench for lcd_cmd_engine with a transfer-level timing model and EN-pulse log.
module tb_lcd_cmd_engine;

  localparam int T_PWRUP = 20;
  localparam int T_SETUP = 2;
  localparam int T_EN    = 4;
  localparam int T_HOLD  = 2;
  localparam int T_CMD   = 10;
  localparam int T_CLR   = 30;
  localparam int LIMIT   = 500;

  localparam int M_PWR  = 0;
  localparam int M_XFER = 1;
  localparam int M_IDLE = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy;
  logic [31:0] io;

  lcd_cmd_engine_if bus ();

  lcd_cmd_engine #(
    .T_PWRUP(T_PWRUP), .T_SETUP(T_SETUP), .T_EN(T_EN),
    .T_HOLD(T_HOLD), .T_CMD(T_CMD), .T_CLR(T_CLR)
  ) dut (
    .i_clk    (clk),
    .i_reset  (rst),
    .wr       (bus),
    .o_busy   (busy),
    .o_io_lcd (io)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transfer-level model ----------------
  // Each write is a block of SETUP+EN+HOLD+exec cycles starting on its accept edge;
  // pins follow the elapsed time within the block and appear one cycle later.
  bit          model_ok = 0;
  int          n, mode, start, dur;
  logic [8:0]  cur;
  logic [8:0]  initq[$];
  logic [31:0] pins_l, exp_io;
  logic        exp_rdy;

  function automatic int exec_len(input logic [8:0] b);
    return (b[8] == 1'b0 && b[7:0] >= 8'd1 && b[7:0] <= 8'd3) ? T_CLR : T_CMD;
  endfunction

  function automatic logic [31:0] pins_at(input logic [8:0] b, input int e);
    logic [31:0] p;
    p = 32'h8000_0000 | (32'(b[8]) << 9) | 32'(b[7:0]);
    if (e >= T_SETUP && e < T_SETUP + T_EN) p = p | 32'h0000_0400;
    return p;
  endfunction

  task automatic begin_xfer(input logic [8:0] b);
    mode  = M_XFER;
    start = n;
    cur   = b;
    dur   = T_SETUP + T_EN + T_HOLD + exec_len(b);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      model_ok = 1;
      n        = 0;
      start    = 0;
      mode     = M_PWR;
      initq    = '{9'h038, 9'h00C, 9'h001, 9'h006};
      exp_io   = 32'h0;
      exp_rdy  = 1'b0;
      pins_l   = 32'h8000_0000;
    end else if (model_ok) begin
      n++;
      exp_io = pins_l;
      case (mode)
        M_PWR:  if (n - start == T_PWRUP) begin_xfer(initq.pop_front());
        M_XFER: if (n - start == dur) begin
          if (initq.size() > 0) begin_xfer(initq.pop_front());
          else mode = M_IDLE;
        end
        M_IDLE: if (bus.wr_vld) begin_xfer({bus.wr_rs, bus.wr_data});
        default: ;
      endcase
      pins_l  = (mode == M_XFER) ? pins_at(cur, n - start) : 32'h8000_0000;
      exp_rdy = (mode == M_IDLE);
    end
  end

  // ---------------- per-cycle compare + EN pulse log ----------------
  logic [8:0] en_log[$];
  logic       prev_en = 1'b0;

  always @(negedge clk) begin
    if (model_ok) begin
      check("io_lcd", io, exp_io);
      check("wr_rdy", 32'(bus.wr_rdy), 32'(exp_rdy));
      check("busy", 32'(busy), 32'(!exp_rdy));
      if (io[10] && !prev_en) en_log.push_back({io[9], io[7:0]});
      prev_en = io[10];
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [31:0] hist[$];

  task automatic wait_rdy(input string nm);
    int k = 0;
    @(negedge clk);
    while (!bus.wr_rdy && k < LIMIT) begin
      @(negedge clk);
      k++;
    end
    if (!bus.wr_rdy) check({nm, " timeout"}, 32'(bus.wr_rdy), 32'd1);
  endtask

  // Issue one write and return cycles from the accept cycle until ready again.
  task automatic do_write(input string nm, input logic rs, input logic [7:0] d,
                          output int lat);
    wait_rdy(nm);
    bus.wr_vld  = 1'b1;
    bus.wr_rs   = rs;
    bus.wr_data = d;
    @(posedge clk);
    #1 bus.wr_vld = 1'b0;
    lat = 0;
    hist.delete();
    do begin
      @(negedge clk);
      lat++;
      hist.push_back(io);
    end while (!bus.wr_rdy && lat < LIMIT);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got time %0t want < 100000", $time);
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int         lat, k, n_on;
    logic [8:0] exp_log[$];

    bus.wr_vld  = 1'b0;
    bus.wr_rs   = 1'b0;
    bus.wr_data = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset io", io, 32'h0);
    check("reset busy", 32'(busy), 32'd1);
    check("reset rdy", 32'(bus.wr_rdy), 32'd0);
    rst = 1'b0;

    // Power-up: ON alone for T_PWRUP cycles, then first init byte in SETUP.
    n_on = 0;
    @(negedge clk);
    while (io == 32'h8000_0000 && n_on < 100) begin
      n_on++;
      @(negedge clk);
    end
    check("pwrup on cycles", 32'(n_on), 32'd20);
    check("first init setup", io, 32'h8000_0038);

    // Data write 0x41: pin words by phase and ready latency.
    do_write("w41", 1'b1, 8'h41, lat);
    check("w41 latency", 32'(lat), 32'd19);
    check("w41 idle pins", hist[0], 32'h8000_0000);
    check("w41 setup a", hist[1], 32'h8000_0241);
    check("w41 setup b", hist[2], 32'h8000_0241);
    check("w41 pulse a", hist[3], 32'h8000_0641);
    check("w41 pulse b", hist[6], 32'h8000_0641);
    check("w41 hold", hist[7], 32'h8000_0241);

    // Clear/home commands take the long execute wait, others the short one.
    do_write("c01", 1'b0, 8'h01, lat);
    check("c01 latency", 32'(lat), 32'd39);
    do_write("c02", 1'b0, 8'h02, lat);
    check("c02 latency", 32'(lat), 32'd39);
    do_write("c80", 1'b0, 8'h80, lat);
    check("c80 latency", 32'(lat), 32'd19);

    // Back-to-back with valid held high.
    wait_rdy("b2b");
    bus.wr_vld  = 1'b1;
    bus.wr_rs   = 1'b1;
    bus.wr_data = 8'h41;
    @(posedge clk);
    #1 bus.wr_data = 8'h42;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.wr_rdy && k < LIMIT);
    check("b2b latency", 32'(k), 32'd19);
    @(posedge clk);
    #1 bus.wr_vld = 1'b0;
    @(negedge clk);
    check("b2b second accepted", 32'(bus.wr_rdy), 32'd0);

    // Reset during the EN pulse of a data write.
    wait_rdy("abort");
    bus.wr_vld  = 1'b1;
    bus.wr_rs   = 1'b1;
    bus.wr_data = 8'h41;
    @(posedge clk);
    #1 bus.wr_vld = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!io[10] && k < LIMIT);
    check("abort saw en", 32'(io[10]), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort io", io, 32'h0);
    check("abort busy", 32'(busy), 32'd1);
    rst = 1'b0;

    // Valid pulsed while busy must be ignored.
    wait_rdy("replay");
    bus.wr_vld  = 1'b1;
    bus.wr_rs   = 1'b1;
    bus.wr_data = 8'h55;
    @(posedge clk);
    #1 bus.wr_vld = 1'b0;
    repeat (12) @(negedge clk);
    bus.wr_vld  = 1'b1;
    bus.wr_data = 8'h66;
    check("busy pulse rdy", 32'(bus.wr_rdy), 32'd0);
    @(negedge clk);
    bus.wr_vld = 1'b0;
    wait_rdy("tail");
    repeat (3) @(negedge clk);

    // Every byte must have produced exactly one EN pulse, in order.
    exp_log = '{9'h038, 9'h00C, 9'h001, 9'h006, 9'h141, 9'h001, 9'h002, 9'h080,
                9'h141, 9'h142, 9'h141,
                9'h038, 9'h00C, 9'h001, 9'h006, 9'h155};
    check("en pulse count", 32'(en_log.size()), 32'(exp_log.size()));
    for (int i = 0; i < exp_log.size(); i++) begin
      if (i < en_log.size()) check($sformatf("en byte %0d", i), 32'(en_log[i]), 32'(exp_log[i]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
